avg_div_sched: RTL and testbench

//  Frame-end scheduler for the black-level averaging path. Latches CH per-channel pixel sums and

---
 rtl/avg_div_sched_pkg.sv | 28 ++
 rtl/avg_div_sched_if.sv | 16 +
 rtl/avg_div_tag_pipe.sv | 33 +++
 rtl/avg_div_sched.sv | 129 ++++++++++++
 tb/tb_avg_div_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/avg_div_sched_pkg.sv
// Shared constants, FSM encoding and saturation helper for the frame-end
// averaging scheduler.
package avg_div_sched_pkg;

  localparam int CH      = 4;
  localparam int SUM_W   = 24;
  localparam int CNT_W   = 12;
  localparam int Q_W     = 13;
  localparam int OUT_W   = 10;
  localparam int DIV_LAT = 13;

  localparam int CH_W    = $clog2(CH);
  localparam int TMO_W   = $clog2(DIV_LAT + 3) + 1;
  localparam int GUARD_W = $clog2(DIV_LAT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [Q_W-1:0]   AVG_MAX_Q = Q_W'((1 << OUT_W) - 1);
  localparam logic [OUT_W-1:0] AVG_MAX   = '1;

  function automatic logic [OUT_W-1:0] sat_avg(input logic [Q_W-1:0] q);
    return (q > AVG_MAX_Q) ? AVG_MAX : q[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/avg_div_sched_if.sv
// Link between the scheduler and the shared pipelined divider.
interface avg_div_sched_if;
  import avg_div_sched_pkg::*;

  // div_en is a fire-and-forget issue strobe (the divider never stalls);
  // div_rdy pulses exactly DIV_LAT cycles after each div_en with div_quot valid.
  logic             div_en;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic             div_rdy;
  logic [Q_W-1:0]   div_quot;

  modport master (output div_en, div_dividend, div_divisor, input div_rdy, div_quot);
  modport slave  (input div_en, div_dividend, div_divisor, output div_rdy, div_quot);

endinterface

// File: rtl/avg_div_tag_pipe.sv
// {valid,chan} shift register matching the divider latency, so each returning
// quotient can be paired with the channel that issued it.
module avg_div_tag_pipe
  import avg_div_sched_pkg::*;
#(
  parameter int DEPTH = DIV_LAT,
  parameter int TW    = CH_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [TW-1:0] push_chan,
  output logic          pop_valid,
  output logic [TW-1:0] pop_chan
);

  logic [DEPTH-1:0]         vld;
  logic [DEPTH-1:0][TW-1:0] chn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
      chn <= '0;
    end else begin
      vld <= {vld[DEPTH-2:0], push};
      chn <= {chn[DEPTH-2:0], push_chan};
    end
  end

  assign pop_valid = vld[DEPTH-1];
  assign pop_chan  = chn[DEPTH-1];

endmodule

// File: rtl/avg_div_sched.sv
// Frame-end scheduler: latches per-channel sums/counts, issues one division per
// cycle, collects tagged quotients and publishes a saturated average vector.
module avg_div_sched
  import avg_div_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [CH*SUM_W-1:0]    sum_in,
  input  logic [CH*CNT_W-1:0]    cnt_in,
  avg_div_sched_if.master        div,
  output logic                   busy,
  output logic                   done,
  output logic [CH*OUT_W-1:0]    avg_out,
  output logic [CH-1:0]          zero_flag,
  output logic                   err,
  output logic [1:0]             dbg_state
);

  localparam int RCW = CH_W + 1;

  logic [1:0]                  state, state_nxt;
  logic [CH_W-1:0]             chan_idx;
  logic [CH-1:0][SUM_W-1:0]    sum_q;
  logic [CH-1:0][CNT_W-1:0]    cnt_q;
  logic [CH-1:0][OUT_W-1:0]    shadow, shadow_nxt;
  logic [CH-1:0]               zf_sh, zf_nxt;
  logic [RCW-1:0]              recv_cnt, recv_nxt;
  logic [TMO_W-1:0]            drain_cnt;
  logic [GUARD_W-1:0]          guard;
  logic                        issuing, cnt_zero, skip, rdy_hit, orphan;
  logic                        all_rcv, timeout, start_acc, err_set;
  logic                        pop_valid;
  logic [CH_W-1:0]             pop_chan;

  assign issuing  = (state == ST_ISSUE);
  assign cnt_zero = (cnt_q[chan_idx] == '0);
  assign skip     = issuing && cnt_zero;

  assign div.div_en       = issuing && !cnt_zero;
  assign div.div_dividend = issuing ? sum_q[chan_idx] : '0;
  assign div.div_divisor  = issuing ? cnt_q[chan_idx] : '0;

  avg_div_tag_pipe #(.DEPTH(DIV_LAT), .TW(CH_W)) u_tag_pipe (
    .clk       (clk),
    .rstn      (rstn),
    .push      (div.div_en),
    .push_chan (chan_idx),
    .pop_valid (pop_valid),
    .pop_chan  (pop_chan)
  );

  assign rdy_hit = div.div_rdy && pop_valid;
  assign orphan  = div.div_rdy && !pop_valid;

  always_comb begin
    shadow_nxt = shadow;
    zf_nxt     = zf_sh;
    if (skip) begin
      shadow_nxt[chan_idx] = '0;
      zf_nxt[chan_idx]     = 1'b1;
    end
    if (rdy_hit) shadow_nxt[pop_chan] = sat_avg(div.div_quot);
    recv_nxt = recv_cnt + RCW'(skip) + RCW'(rdy_hit);
  end

  assign all_rcv   = (recv_nxt == RCW'(CH));
  assign timeout   = (state == ST_DRAIN) && (drain_cnt == TMO_W'(DIV_LAT + 2)) && !all_rcv;
  assign start_acc = start && (state == ST_IDLE);
  // Results still in the divider when reset hit come back within DIV_LAT
  // cycles with no tag; the guard window keeps them from flagging err.
  assign err_set   = (start && (state != ST_IDLE)) || timeout || (orphan && (guard == '0));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: if (chan_idx == CH_W'(CH - 1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (all_rcv || timeout) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      chan_idx  <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      shadow    <= '0;
      zf_sh     <= '0;
      recv_cnt  <= '0;
      drain_cnt <= '0;
      guard     <= GUARD_W'(DIV_LAT);
      avg_out   <= '0;
      zero_flag <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (guard != '0) guard <= guard - 1'b1;
      if (start_acc) begin
        sum_q     <= sum_in;
        cnt_q     <= cnt_in;
        chan_idx  <= '0;
        shadow    <= '0;
        zf_sh     <= '0;
        recv_cnt  <= '0;
        drain_cnt <= '0;
      end else begin
        shadow   <= shadow_nxt;
        zf_sh    <= zf_nxt;
        recv_cnt <= recv_nxt;
        if (issuing) chan_idx <= chan_idx + 1'b1;
        if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      end
      if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
        avg_out   <= shadow_nxt;
        zero_flag <= zf_nxt;
      end
      if (err_set) err <= 1'b1;
      else if (start_acc) err <= 1'b0;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_avg_div_sched.sv
// Directed bench for avg_div_sched with a behavioural fixed-latency divider.
module tb_avg_div_sched;
  import avg_div_sched_pkg::*;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                start = 1'b0;
  logic [CH*SUM_W-1:0] sum_in = '0;
  logic [CH*CNT_W-1:0] cnt_in = '0;
  logic                busy, done, err;
  logic [CH*OUT_W-1:0] avg_out;
  logic [CH-1:0]       zero_flag;
  logic [1:0]          dbg_state;
  int                  total = 0;
  int                  bad = 0;

  avg_div_sched_if div_bus ();

  avg_div_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .sum_in    (sum_in),
    .cnt_in    (cnt_in),
    .div       (div_bus.master),
    .busy      (busy),
    .done      (done),
    .avg_out   (avg_out),
    .zero_flag (zero_flag),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Divider model: not reset by rstn, so in-flight results survive a reset.
  logic [DIV_LAT-1:0] m_v = '0;
  logic [Q_W-1:0]     m_q [DIV_LAT];
  int                 issue_cnt = 0;
  int                 drop_at = -1;

  function automatic logic [Q_W-1:0] model_quot(input logic [SUM_W-1:0] a, input logic [CNT_W-1:0] b);
    longint unsigned q;
    if (b == '0) return '0;
    q = longint'(a) / longint'(b);
    return (q > 64'd8191) ? 13'd8191 : q[Q_W-1:0];
  endfunction

  always @(posedge clk) begin
    m_v <= {m_v[DIV_LAT-2:0], div_bus.div_en && (issue_cnt != drop_at)};
    for (int s = DIV_LAT - 1; s > 0; s--) m_q[s] <= m_q[s-1];
    m_q[0] <= model_quot(div_bus.div_dividend, div_bus.div_divisor);
    if (div_bus.div_en) issue_cnt <= issue_cnt + 1;
  end

  assign div_bus.div_rdy  = m_v[DIV_LAT-1];
  assign div_bus.div_quot = m_q[DIV_LAT-1];

  function automatic logic [CH*SUM_W-1:0] pack_sum(input int a0, input int a1, input int a2, input int a3);
    return {SUM_W'(a3), SUM_W'(a2), SUM_W'(a1), SUM_W'(a0)};
  endfunction

  function automatic logic [CH*CNT_W-1:0] pack_cnt(input int a0, input int a1, input int a2, input int a3);
    return {CNT_W'(a3), CNT_W'(a2), CNT_W'(a1), CNT_W'(a0)};
  endfunction

  function automatic logic [CH*OUT_W-1:0] pack_avg(input int a0, input int a1, input int a2, input int a3);
    return {OUT_W'(a3), OUT_W'(a2), OUT_W'(a1), OUT_W'(a0)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 after the start edge.
  task automatic pulse_start(input logic [CH*SUM_W-1:0] s, input logic [CH*CNT_W-1:0] c);
    sum_in = s;
    cnt_in = c;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (!done && lat < 80) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int base;
    int dcnt;
    logic [CH*SUM_W-1:0] s1, s2, s3;
    logic [CH*CNT_W-1:0] c1, c2, c3;
    s1 = pack_sum(4096, 8192, 1000, 0);    c1 = pack_cnt(16, 32, 10, 5);
    s2 = pack_sum(1000, 999, 777, 5000);   c2 = pack_cnt(10, 3, 0, 7);
    s3 = pack_sum(8388607, 1023, 1024, 2045); c3 = pack_cnt(1, 1, 1, 2);

    // reset state
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_avg", avg_out, 0);
    check("rst_zf", zero_flag, 0);
    check("rst_div_en", div_bus.div_en, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rstn = 1'b1;
    tick();

    // 1: basic frame
    base = issue_cnt;
    pulse_start(s1, c1);
    check("t1_div_en", div_bus.div_en, 1);
    check("t1_dividend", div_bus.div_dividend, 4096);
    check("t1_divisor", div_bus.div_divisor, 16);
    check("t1_busy", busy, 1);
    wait_done(1, lat);
    check("t1_latency", lat, CH + DIV_LAT + 1);
    check("t1_avg", avg_out, pack_avg(256, 256, 100, 0));
    check("t1_zf", zero_flag, 0);
    check("t1_err", err, 0);
    check("t1_issues", issue_cnt - base, 4);
    tick();
    check("t1_done_low", done, 0);
    check("t1_idle", busy, 0);

    // 2: zero count on channel 2
    base = issue_cnt;
    pulse_start(s2, c2);
    check("t2_avg_held", avg_out, pack_avg(256, 256, 100, 0));
    wait_done(1, lat);
    check("t2_latency", lat, CH + DIV_LAT + 1);
    check("t2_issues", issue_cnt - base, 3);
    check("t2_zf", zero_flag, 4'b0100);
    check("t2_avg", avg_out, pack_avg(100, 333, 0, 714));
    tick();

    // 3: saturation, then a start during DONE is ignored
    pulse_start(s3, c3);
    wait_done(1, lat);
    check("t3_latency", lat, CH + DIV_LAT + 1);
    check("t3_avg", avg_out, pack_avg(1023, 1023, 1023, 1022));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_start_in_done_idle", dbg_state, ST_IDLE);
    check("t3_start_in_done_err", err, 1);
    tick();

    // 4: second start three cycles into the frame
    base = issue_cnt;
    pulse_start(s2, c2);
    check("t4_err_cleared", err, 0);
    tick();
    tick();
    sum_in = s1;
    cnt_in = c1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("t4_err_set", err, 1);
    wait_done(4, lat);
    check("t4_latency", lat, CH + DIV_LAT + 1);
    check("t4_avg", avg_out, pack_avg(100, 333, 0, 714));
    check("t4_zf", zero_flag, 4'b0100);
    check("t4_issues", issue_cnt - base, 3);
    dcnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("t4_single_done", dcnt, 0);
    check("t4_err_sticky", err, 1);

    // 5: divider drops channel 1 result
    drop_at = issue_cnt + 1;
    pulse_start(s1, c1);
    check("t5_err_cleared", err, 0);
    wait_done(1, lat);
    drop_at = -1;
    check("t5_latency", lat, CH + DIV_LAT + 4);
    check("t5_err", err, 1);
    check("t5_avg", avg_out, pack_avg(256, 0, 100, 0));
    tick();

    // 6: reset mid-DRAIN, then a fresh frame while old results trickle back
    pulse_start(s1, c1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_err_pre", err, 1);
    repeat (3) tick();
    check("t6_in_drain", dbg_state, ST_DRAIN);
    rstn = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_avg", avg_out, 0);
    check("t6_rst_state", dbg_state, ST_IDLE);
    tick();
    rstn = 1'b1;
    pulse_start(s3, c3);
    wait_done(1, lat);
    check("t6_latency", lat, CH + DIV_LAT + 1);
    check("t6_avg", avg_out, pack_avg(1023, 1023, 1023, 1022));
    check("t6_err", err, 0);
    repeat (20) tick();
    check("t6_err_late", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
